mips32_test_sequencer: RTL and testbench

MIPS32_TEST_SEQUENCER -- requirements
Module: mips32_test_sequencer

---
 rtl/mips32_test_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_mips32_test_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_test_sequencer.sv
// Test sequencer for a MIPS32 core. It loads a program into instruction
// memory, runs the core until it reaches a stop PC or a cycle limit, and
// then streams the register file, data memory and a status word out over a
// valid/ready dump port.
module mips32_test_sequencer #(
    parameter int          PROG_DEPTH = 16,
    parameter logic [31:0] STOP_PC    = 32'h0000_0008,
    parameter int          MAX_CYCLES = 1024,
    parameter int          NUM_REGS   = 32,
    parameter int          DMEM_WORDS = 64,
    parameter bit          DUMP_MEM   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [15:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_run,
    input  logic [31:0] cpu_pc,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [15:0] dm_raddr,
    input  logic [31:0] dm_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [1:0]  dump_tag,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_DUMP_REG = 3'd3,
        S_DUMP_MEM = 3'd4,
        S_STATUS   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [15:0] PROG_LAST = 16'(PROG_DEPTH - 1);
    localparam logic [4:0]  RF_LAST   = 5'(NUM_REGS - 1);
    localparam logic [15:0] DM_LAST   = 16'(DMEM_WORDS - 1);
    localparam logic [31:0] CYC_LAST  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] CYC_SAT   = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [15:0] prog_addr_q, prog_addr_d;
    logic [4:0]  rf_raddr_q, rf_raddr_d;
    logic [15:0] dm_raddr_q, dm_raddr_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        timeout_q, timeout_d;
    // Output flags are registered from the next state so they are clean
    // flop outputs that always agree with state_q.
    logic        imem_we_q, imem_we_d;
    logic        cpu_run_q, cpu_run_d;
    logic        dump_valid_q, dump_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  dump_tag_q, dump_tag_d;
    logic        xfer_s;

    assign xfer_s = dump_valid_q && dump_ready;

    // Next-state, index/counter updates and next output flags.
    always_comb begin
        state_d       = state_q;
        prog_addr_d   = prog_addr_q;
        rf_raddr_d    = rf_raddr_q;
        dm_raddr_d    = dm_raddr_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    prog_addr_d   = 16'd0;
                    cycle_count_d = 32'd0;
                    timeout_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (prog_addr_q == PROG_LAST) begin
                    state_d     = S_RUN;
                    prog_addr_d = 16'd0;
                end else begin
                    prog_addr_d = prog_addr_q + 16'd1;
                end
            end
            S_RUN: begin
                // The cycle that sees the stop PC is still counted.
                cycle_count_d = (cycle_count_q == CYC_SAT) ? cycle_count_q
                                                           : cycle_count_q + 32'd1;
                if (cpu_pc == STOP_PC) begin
                    state_d = S_DUMP_REG;
                end else if (cycle_count_q == CYC_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DUMP_REG;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DUMP_REG: begin
                if (xfer_s) begin
                    if (rf_raddr_q == RF_LAST) begin
                        rf_raddr_d = 5'd0;
                        state_d    = DUMP_MEM ? S_DUMP_MEM : S_STATUS;
                    end else begin
                        rf_raddr_d = rf_raddr_q + 5'd1;
                    end
                end else begin
                    rf_raddr_d = rf_raddr_q;
                end
            end
            S_DUMP_MEM: begin
                if (xfer_s) begin
                    if (dm_raddr_q == DM_LAST) begin
                        dm_raddr_d = 16'd0;
                        state_d    = S_STATUS;
                    end else begin
                        dm_raddr_d = dm_raddr_q + 16'd1;
                    end
                end else begin
                    dm_raddr_d = dm_raddr_q;
                end
            end
            S_STATUS: begin
                if (xfer_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STATUS;
                end
            end
            default: state_d = S_IDLE;
        endcase

        imem_we_d    = (state_d == S_LOAD);
        cpu_run_d    = (state_d == S_RUN);
        dump_valid_d = (state_d == S_DUMP_REG) || (state_d == S_DUMP_MEM) ||
                       (state_d == S_STATUS);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
        case (state_d)
            S_DUMP_MEM: dump_tag_d = 2'd1;
            S_STATUS:   dump_tag_d = 2'd2;
            default:    dump_tag_d = 2'd0;
        endcase
    end

    // State, indices, counters and registered output flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            prog_addr_q   <= 16'd0;
            rf_raddr_q    <= 5'd0;
            dm_raddr_q    <= 16'd0;
            cycle_count_q <= 32'd0;
            timeout_q     <= 1'b0;
            imem_we_q     <= 1'b0;
            cpu_run_q     <= 1'b0;
            dump_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            dump_tag_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            prog_addr_q   <= prog_addr_d;
            rf_raddr_q    <= rf_raddr_d;
            dm_raddr_q    <= dm_raddr_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            imem_we_q     <= imem_we_d;
            cpu_run_q     <= cpu_run_d;
            dump_valid_q  <= dump_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            dump_tag_q    <= dump_tag_d;
        end
    end

    // Dump payload follows the combinational read ports; indices only move
    // on a transfer, so the word is stable while the sink stalls.
    always_comb begin
        case (state_q)
            S_DUMP_REG: dump_data = rf_rdata;
            S_DUMP_MEM: dump_data = dm_rdata;
            S_STATUS:   dump_data = {timeout_q, cycle_count_q[30:0]};
            default:    dump_data = 32'd0;
        endcase
    end

    assign prog_addr   = prog_addr_q;
    assign imem_addr   = prog_addr_q;
    assign imem_wdata  = prog_data;
    assign imem_we     = imem_we_q;
    assign cpu_run     = cpu_run_q;
    assign rf_raddr    = rf_raddr_q;
    assign dm_raddr    = dm_raddr_q;
    assign dump_valid  = dump_valid_q;
    assign dump_tag    = dump_tag_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips32_test_sequencer.sv
// Scoreboard bench for mips32_test_sequencer: stimulus pushes expected imem
// writes and dump beats into queues; monitors pop and compare on the
// falling edge.
module tb_mips32_test_sequencer;

    logic        clock;
    logic        reset_n;
    // main instance (DUMP_MEM=1)
    logic        start;
    logic [15:0] prog_addr;
    logic [31:0] prog_data;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic [31:0] cpu_pc;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [15:0] dm_raddr;
    logic [31:0] dm_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [1:0]  dump_tag;
    logic        busy, done, timeout;
    logic [31:0] cycle_count;
    // second instance (DUMP_MEM=0)
    logic        start2;
    logic [15:0] prog_addr2;
    logic [31:0] prog_data2;
    logic        imem_we2;
    logic [15:0] imem_addr2;
    logic [31:0] imem_wdata2;
    logic        cpu_run2;
    logic [31:0] cpu_pc2;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic [15:0] dm_raddr2;
    logic [31:0] dm_rdata2;
    logic        dump_valid2;
    logic        dump_ready2;
    logic [31:0] dump_data2;
    logic [1:0]  dump_tag2;
    logic        busy2, done2, timeout2;
    logic [31:0] cycle_count2;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] sb_q[$];
    logic [33:0] sb2_q[$];
    int          imem_q[$];

    // processor model: pc derived from the number of run cycles seen
    int          pc_mode;
    logic        pc_clr;
    logic [31:0] run_cnt;

    mips32_test_sequencer #(
        .PROG_DEPTH(4), .STOP_PC(32'd8), .MAX_CYCLES(16),
        .NUM_REGS(32), .DMEM_WORDS(4), .DUMP_MEM(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_run(cpu_run), .cpu_pc(cpu_pc),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_tag(dump_tag),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    mips32_test_sequencer #(
        .PROG_DEPTH(4), .STOP_PC(32'd8), .MAX_CYCLES(16),
        .NUM_REGS(32), .DMEM_WORDS(4), .DUMP_MEM(1'b0)
    ) dut_nomem (
        .clock(clock), .reset_n(reset_n), .start(start2),
        .prog_addr(prog_addr2), .prog_data(prog_data2),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .cpu_run(cpu_run2), .cpu_pc(cpu_pc2),
        .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
        .dm_raddr(dm_raddr2), .dm_rdata(dm_rdata2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready2),
        .dump_data(dump_data2), .dump_tag(dump_tag2),
        .busy(busy2), .done(done2), .timeout(timeout2), .cycle_count(cycle_count2)
    );

    // memory models: contents encode their index
    assign prog_data  = 32'hA000_0000 + {16'd0, prog_addr};
    assign rf_rdata   = 32'h1111_0000 + {27'd0, rf_raddr};
    assign dm_rdata   = 32'hD000_0000 + {16'd0, dm_raddr};
    assign prog_data2 = 32'hA000_0000 + {16'd0, prog_addr2};
    assign rf_rdata2  = 32'h1111_0000 + {27'd0, rf_raddr2};
    assign dm_rdata2  = 32'hD000_0000 + {16'd0, dm_raddr2};
    assign cpu_pc2    = 32'd8;

    assign cpu_pc = (pc_mode == 0) ? {run_cnt[29:0], 2'b00} :
                    ((pc_mode == 2) && (run_cnt == 32'd15)) ? 32'd8 : 32'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)    run_cnt <= 32'd0;
        else if (pc_clr) run_cnt <= 32'd0;
        else if (cpu_run) run_cnt <= run_cnt + 32'd1;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // imem write monitor
    always @(negedge clock) begin
        if (reset_n && imem_we) begin
            if (imem_q.size() == 0) begin
                chk32("imem_extra_write", 32'd1, 32'd0);
            end else begin
                int e;
                e = imem_q.pop_front();
                chk32("imem_addr", {16'd0, imem_addr}, 32'(e));
                chk32("imem_wdata", imem_wdata, 32'hA000_0000 + 32'(e));
            end
        end
    end

    // dump monitors: pop on transfer, check held beat against front on stall
    always @(negedge clock) begin
        if (reset_n && dump_valid) begin
            if (sb_q.size() == 0) begin
                chk32("dump_extra_beat", {30'd0, dump_tag}, 32'hFFFF_FFFF);
            end else if (dump_ready) begin
                logic [33:0] e;
                e = sb_q.pop_front();
                chk32("dump_tag", {30'd0, dump_tag}, {30'd0, e[33:32]});
                chk32("dump_data", dump_data, e[31:0]);
            end else begin
                chk32("stall_tag", {30'd0, dump_tag}, {30'd0, sb_q[0][33:32]});
                chk32("stall_data", dump_data, sb_q[0][31:0]);
            end
        end
        if (reset_n && dump_valid2 && dump_ready2) begin
            if (sb2_q.size() == 0) begin
                chk32("nomem_extra_beat", {30'd0, dump_tag2}, 32'hFFFF_FFFF);
            end else begin
                logic [33:0] e2;
                e2 = sb2_q.pop_front();
                chk32("nomem_tag", {30'd0, dump_tag2}, {30'd0, e2[33:32]});
                chk32("nomem_data", dump_data2, e2[31:0]);
            end
        end
    end

    task automatic push_dump(input bit second, input bit with_mem, input logic [31:0] status);
        for (int i = 0; i < 32; i++) begin
            if (second) sb2_q.push_back({2'd0, 32'h1111_0000 + 32'(i)});
            else        sb_q.push_back({2'd0, 32'h1111_0000 + 32'(i)});
        end
        if (with_mem) begin
            for (int i = 0; i < 4; i++) sb_q.push_back({2'd1, 32'hD000_0000 + 32'(i)});
        end
        if (second) sb2_q.push_back({2'd2, status});
        else        sb_q.push_back({2'd2, status});
    endtask

    task automatic run_main(input int mode, input bit toggle, input logic [31:0] exp_cc,
                            input logic exp_to, input logic [31:0] exp_status);
        bit seen;
        pc_mode = mode;
        for (int i = 0; i < 4; i++) imem_q.push_back(i);
        push_dump(1'b0, 1'b1, exp_status);
        @(posedge clock); #1 pc_clr = 1'b1;
        @(posedge clock); #1 pc_clr = 1'b0; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clock); #1;
            if (toggle) dump_ready = ~dump_ready;
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk32("done_reached", {31'd0, seen}, 32'd1);
        chk32("cycle_count", cycle_count, exp_cc);
        chk32("timeout", {31'd0, timeout}, {31'd0, exp_to});
        chk32("run_cycles", run_cnt, exp_cc);
        chk32("busy_at_done", {31'd0, busy}, 32'd0);
        chk32("beats_left", 32'(sb_q.size()), 32'd0);
        chk32("imem_left", 32'(imem_q.size()), 32'd0);
        dump_ready = 1'b1;
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
        dump_ready = 1'b1; dump_ready2 = 1'b1;
        pc_mode = 0; pc_clr = 1'b0;
        #12;
        chk32("rst_busy", {31'd0, busy}, 32'd0);
        chk32("rst_done", {31'd0, done}, 32'd0);
        chk32("rst_flags", {28'd0, imem_we, cpu_run, dump_valid, timeout}, 32'd0);
        chk32("rst_cycle_count", cycle_count, 32'd0);
        chk32("rst_addrs", {prog_addr, 11'd0, rf_raddr}, 32'd0);
        chk32("rst_dump", dump_data | {30'd0, dump_tag}, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // ideal core, stop at pc 8 after 3 run cycles
        run_main(0, 1'b0, 32'd3, 1'b0, 32'h0000_0003);
        // pc stuck at 0: timeout after 16 run cycles
        run_main(1, 1'b0, 32'd16, 1'b1, 32'h8000_0010);
        // stop coincides with last allowed cycle: stop wins
        run_main(2, 1'b0, 32'd16, 1'b0, 32'h0000_0010);
        // sink stalling every other cycle
        run_main(0, 1'b1, 32'd3, 1'b0, 32'h0000_0003);

        // no-memory-dump instance: pc already 8, stops on first run cycle
        push_dump(1'b1, 1'b0, 32'h0000_0001);
        @(posedge clock); #1 start2 = 1'b1;
        @(posedge clock); #1 start2 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (done2) begin
                seen = 1'b1;
                break;
            end
        end
        chk32("nomem_done", {31'd0, seen}, 32'd1);
        chk32("nomem_cycle_count", cycle_count2, 32'd1);
        chk32("nomem_beats_left", 32'(sb2_q.size()), 32'd0);

        // reset pulse in the middle of RUN
        pc_mode = 1;
        for (int i = 0; i < 4; i++) imem_q.push_back(i);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (cpu_run) begin
                seen = 1'b1;
                break;
            end
        end
        chk32("abort_reached_run", {31'd0, seen}, 32'd1);
        @(posedge clock); @(posedge clock); #1 reset_n = 1'b0;
        #1;
        chk32("abort_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk32("abort_busy", {31'd0, busy}, 32'd0);
        chk32("abort_cycle_count", cycle_count, 32'd0);
        chk32("abort_flags", {29'd0, imem_we, dump_valid, done}, 32'd0);
        chk32("abort_imem_left", 32'(imem_q.size()), 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        // fresh run reloads all four words
        run_main(0, 1'b0, 32'd3, 1'b0, 32'h0000_0003);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
